// File: rtl/ddr_axi_pkg.sv
// Shared AXI4 constants, response codes and helpers for the DDR3 read-port arbiter.
package ddr_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int unsigned AXI_4KB = 4096;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_e;

   // AxSIZE encoding for a full-width beat: log2 of the bytes per beat.
   function automatic logic [2:0] axi_size(input int unsigned data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/ddr3_axi_rd_arbiter_rr.sv
// Round-robin request picker: first requester at or after ptr, one-hot and index grant.
module rr_arbiter #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [ID_W-1:0] ptr,
   input  logic            enable,
   output logic            grant_vld,
   output logic [ID_W-1:0] grant_idx,
   output logic [N_CH-1:0] grant_oh
);

   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int unsigned off = 0; off < N_CH; off++) begin
         idx = 32'(ptr) + off;
         if (idx >= N_CH) idx = idx - N_CH;
         if (enable && !grant_vld && req[ID_W'(idx)]) begin
            grant_vld               = 1'b1;
            grant_idx               = ID_W'(idx);
            grant_oh[ID_W'(idx)]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr3_axi_rd_arbiter.sv
// N-channel burst-read arbiter onto one AXI4 read port: round-robin AR issue tagged by
// client index, RID-based R routing, outstanding-burst limit and 4 KB crossing rejection.
module ddr3_axi_rd_arbiter
   import ddr_axi_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned MAX_OUT = 4,
   localparam int unsigned ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic [N_CH-1:0]          c_req_valid,
   output logic [N_CH-1:0]          c_req_ready,
   input  logic [N_CH*ADDR_W-1:0]   c_req_addr,
   input  logic [N_CH*LEN_W-1:0]    c_req_len,
   output logic [N_CH-1:0]          c_req_err,
   output logic [N_CH-1:0]          c_rd_valid,
   input  logic [N_CH-1:0]          c_rd_ready,
   output logic [DATA_W-1:0]        c_rd_data,
   output logic                     c_rd_last,
   output logic                     c_rd_err,
   output logic [ID_W-1:0]          m_axi_arid,
   output logic [ADDR_W-1:0]        m_axi_araddr,
   output logic [7:0]               m_axi_arlen,
   output logic [2:0]               m_axi_arsize,
   output logic [1:0]               m_axi_arburst,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [ID_W-1:0]          m_axi_rid,
   input  logic [DATA_W-1:0]        m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rlast,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
);

   localparam int unsigned BYTES   = DATA_W / 8;
   localparam int unsigned SUM_W   = LEN_W + 16;
   localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [2:0]  AR_SIZE = axi_size(DATA_W);

   arb_state_e          state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
   logic                arvalid_q, arvalid_d;
   logic [ID_W-1:0]     arid_q, arid_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [7:0]          arlen_q, arlen_d;
   logic [N_CH-1:0]     req_err_q, req_err_d;

   logic                arb_en;
   logic                grant_vld;
   logic [ID_W-1:0]     grant_idx;
   logic [N_CH-1:0]     grant_oh;
   logic [ADDR_W-1:0]   sel_addr;
   logic [LEN_W-1:0]    sel_len;
   logic [SUM_W-1:0]    end_off;
   logic                crosses_4kb;
   logic                ar_hs;
   logic                r_last_hs;

   function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
      if (32'(p) == N_CH - 1) return '0;
      return p + ID_W'(1);
   endfunction

   // Reset is folded into the enable so no grant leaks out while aresetn is low.
   assign arb_en = (state_q == IDLE) && (out_cnt_q < CNT_W'(MAX_OUT)) && aresetn;

   rr_arbiter #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .req       (c_req_valid),
      .ptr       (rr_ptr_q),
      .enable    (arb_en),
      .grant_vld (grant_vld),
      .grant_idx (grant_idx),
      .grant_oh  (grant_oh)
   );

   assign c_req_ready = grant_oh;

   // Mux the granted request and test whether its last byte lands past the 4 KB page.
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (grant_oh[i]) begin
            sel_addr = c_req_addr[i*ADDR_W +: ADDR_W];
            sel_len  = c_req_len[i*LEN_W +: LEN_W];
         end
      end
      end_off     = SUM_W'(sel_addr[11:0])
                  + (SUM_W'(sel_len) + SUM_W'(1)) * SUM_W'(BYTES);
      crosses_4kb = end_off > SUM_W'(AXI_4KB);
   end

   assign ar_hs     = arvalid_q && m_axi_arready;
   assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast && (out_cnt_q != '0);

   // Next-state and AR register loading.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      arvalid_d = arvalid_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      req_err_d = '0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               if (crosses_4kb) begin
                  req_err_d = grant_oh;
                  rr_ptr_d  = ptr_inc(grant_idx);
               end else begin
                  arid_d    = grant_idx;
                  araddr_d  = sel_addr;
                  arlen_d   = 8'(sel_len);
                  arvalid_d = 1'b1;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rr_ptr_d  = ptr_inc(arid_q);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      case ({ar_hs, r_last_hs})
         2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
         2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         out_cnt_q <= '0;
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         req_err_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         out_cnt_q <= out_cnt_d;
         arvalid_q <= arvalid_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         req_err_q <= req_err_d;
      end
   end

   assign c_req_err     = req_err_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_arid    = arid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = AR_SIZE;
   assign m_axi_arburst = AXI_BURST_INCR;

   // R routing by RID; beats for an unknown RID are accepted and dropped.
   always_comb begin
      c_rd_valid   = '0;
      m_axi_rready = 1'b1;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (m_axi_rid == ID_W'(i)) begin
            c_rd_valid[i] = m_axi_rvalid;
            m_axi_rready  = c_rd_ready[i];
         end
      end
   end

   assign c_rd_data = m_axi_rdata;
   assign c_rd_last = m_axi_rlast;
   assign c_rd_err  = (m_axi_rresp == AXI_RESP_SLVERR) || (m_axi_rresp == AXI_RESP_DECERR);

endmodule

// File: tb/tb_ddr3_axi_rd_arbiter.sv
// Directed bench for ddr3_axi_rd_arbiter (4 channels, 32-bit data, MAX_OUT=4).
module tb_ddr3_axi_rd_arbiter;

   localparam int unsigned N_CH   = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned ID_W   = 2;

   logic                   clk = 1'b0;
   logic                   aresetn;
   logic [N_CH-1:0]        c_req_valid;
   logic [N_CH-1:0]        c_req_ready;
   logic [N_CH*ADDR_W-1:0] c_req_addr;
   logic [N_CH*LEN_W-1:0]  c_req_len;
   logic [N_CH-1:0]        c_req_err;
   logic [N_CH-1:0]        c_rd_valid;
   logic [N_CH-1:0]        c_rd_ready;
   logic [DATA_W-1:0]      c_rd_data;
   logic                   c_rd_last;
   logic                   c_rd_err;
   logic [ID_W-1:0]        m_axi_arid;
   logic [ADDR_W-1:0]      m_axi_araddr;
   logic [7:0]             m_axi_arlen;
   logic [2:0]             m_axi_arsize;
   logic [1:0]             m_axi_arburst;
   logic                   m_axi_arvalid;
   logic                   m_axi_arready;
   logic [ID_W-1:0]        m_axi_rid;
   logic [DATA_W-1:0]      m_axi_rdata;
   logic [1:0]             m_axi_rresp;
   logic                   m_axi_rlast;
   logic                   m_axi_rvalid;
   logic                   m_axi_rready;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   ddr3_axi_rd_arbiter #(
      .N_CH    (N_CH),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .MAX_OUT (4)
   ) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .c_req_valid   (c_req_valid),
      .c_req_ready   (c_req_ready),
      .c_req_addr    (c_req_addr),
      .c_req_len     (c_req_len),
      .c_req_err     (c_req_err),
      .c_rd_valid    (c_rd_valid),
      .c_rd_ready    (c_rd_ready),
      .c_rd_data     (c_rd_data),
      .c_rd_last     (c_rd_last),
      .c_rd_err      (c_rd_err),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int ch, input logic [31:0] addr, input logic [7:0] len);
      c_req_addr[ch*ADDR_W +: ADDR_W] = addr;
      c_req_len[ch*LEN_W +: LEN_W]    = len;
   endtask

   initial begin
      aresetn       = 1'b0;
      c_req_valid   = '0;
      c_req_addr    = '0;
      c_req_len     = '0;
      c_rd_ready    = '0;
      m_axi_arready = 1'b1;
      m_axi_rid     = '0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      m_axi_rvalid  = 1'b0;

      // Reset values
      #3;
      check("rst_req_ready", 32'(c_req_ready), 32'h0);
      check("rst_req_err",   32'(c_req_err),   32'h0);
      check("rst_arvalid",   32'(m_axi_arvalid), 32'h0);
      check("rst_arburst",   32'(m_axi_arburst), 32'h1);
      check("rst_arsize",    32'(m_axi_arsize),  32'h2);
      check("rst_araddr",    m_axi_araddr,       32'h0);
      check("rst_arlen",     32'(m_axi_arlen),   32'h0);
      check("rst_arid",      32'(m_axi_arid),    32'h0);
      #9;
      aresetn = 1'b1;
      step();

      // Single 8-beat burst on ch2
      set_req(2, 32'hBC00_0100, 8'd7);
      c_req_valid = 4'b0100;
      #1;
      check("t1_req_ready", 32'(c_req_ready), 32'h4);
      step();
      c_req_valid = '0;
      #1;
      check("t1_arvalid", 32'(m_axi_arvalid), 32'h1);
      check("t1_arid",    32'(m_axi_arid),    32'h2);
      check("t1_araddr",  m_axi_araddr,       32'hBC00_0100);
      check("t1_arlen",   32'(m_axi_arlen),   32'h7);
      check("t1_arburst", 32'(m_axi_arburst), 32'h1);
      check("t1_ready_in_issue", 32'(c_req_ready), 32'h0);
      step();
      check("t1_arvalid_drop", 32'(m_axi_arvalid), 32'h0);
      check("t1_out_cnt1", 32'(dut.out_cnt_q), 32'h1);
      c_rd_ready = 4'b0100;
      for (int b = 0; b < 8; b++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rid    = 2'd2;
         m_axi_rdata  = 32'hD000_0000 + 32'(b);
         m_axi_rlast  = (b == 7);
         m_axi_rresp  = (b == 3) ? 2'b10 : 2'b00;
         #1;
         check("t1_rd_valid", 32'(c_rd_valid), 32'h4);
         check("t1_rready",   32'(m_axi_rready), 32'h1);
         check("t1_rd_last",  32'(c_rd_last), (b == 7) ? 32'h1 : 32'h0);
         check("t1_rd_data",  c_rd_data, 32'hD000_0000 + 32'(b));
         check("t1_rd_err",   32'(c_rd_err), (b == 3) ? 32'h1 : 32'h0);
         step();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      c_rd_ready   = '0;
      #1;
      check("t1_out_cnt0", 32'(dut.out_cnt_q), 32'h0);

      // 4 KB crossing on ch1 (0xFF0 + 32 > 4096); ch2 ends exactly on 4096 and is accepted
      set_req(1, 32'h0000_0FF0, 8'd7);
      set_req(2, 32'h0000_0FE0, 8'd7);
      c_req_valid = 4'b0110;
      #1;
      check("t3_ready_ch1", 32'(c_req_ready), 32'h2);
      step();
      c_req_valid = 4'b0100;
      #1;
      check("t3_err_ch1",    32'(c_req_err),     32'h2);
      check("t3_no_ar",      32'(m_axi_arvalid), 32'h0);
      check("t3_ready_ch2",  32'(c_req_ready),   32'h4);
      step();
      c_req_valid = '0;
      check("t3_err_clear",  32'(c_req_err),     32'h0);
      check("t3_arvalid",    32'(m_axi_arvalid), 32'h1);
      check("t3_arid",       32'(m_axi_arid),    32'h2);
      check("t3_araddr",     m_axi_araddr,       32'h0000_0FE0);
      step();
      check("t3_out_cnt", 32'(dut.out_cnt_q), 32'h1);

      // AR stall for 10 cycles with a competing request on ch3
      m_axi_arready = 1'b0;
      set_req(0, 32'h0000_0080, 8'd1);
      set_req(3, 32'h0000_0200, 8'd0);
      c_req_valid = 4'b0001;
      #1;
      check("t4_ready_ch0", 32'(c_req_ready), 32'h1);
      step();
      c_req_valid = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("t4_arvalid_hold", 32'(m_axi_arvalid), 32'h1);
         check("t4_arid_hold",    32'(m_axi_arid),    32'h0);
         check("t4_araddr_hold",  m_axi_araddr,       32'h0000_0080);
         check("t4_arlen_hold",   32'(m_axi_arlen),   32'h1);
         check("t4_no_grant",     32'(c_req_ready),   32'h0);
         step();
      end
      m_axi_arready = 1'b1;
      step();
      check("t4_out_cnt2",  32'(dut.out_cnt_q), 32'h2);
      check("t4_ready_ch3", 32'(c_req_ready),   32'h8);
      step();
      c_req_valid = 4'b0010;
      set_req(1, 32'h0000_0300, 8'd0);
      check("t4_arid_ch3", 32'(m_axi_arid), 32'h3);
      step();
      check("t5_out_cnt3",  32'(dut.out_cnt_q), 32'h3);
      check("t5_ready_ch1", 32'(c_req_ready),   32'h2);
      step();
      c_req_valid = '0;

      // Coincident AR and rlast handshake at out_cnt=3
      m_axi_rvalid = 1'b1;
      m_axi_rid    = 2'd2;
      m_axi_rlast  = 1'b1;
      c_rd_ready   = 4'b0100;
      #1;
      check("t5_arvalid", 32'(m_axi_arvalid), 32'h1);
      check("t5_rready",  32'(m_axi_rready),  32'h1);
      step();
      m_axi_rvalid = 1'b0;
      #1;
      check("t5_out_cnt_same", 32'(dut.out_cnt_q),   32'h3);
      check("t5_arvalid_drop", 32'(m_axi_arvalid),   32'h0);

      // R back-pressure on ch1
      m_axi_rvalid = 1'b1;
      m_axi_rid    = 2'd1;
      m_axi_rlast  = 1'b1;
      c_rd_ready   = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t5_bp_rready",   32'(m_axi_rready), 32'h0);
         check("t5_bp_rd_valid", 32'(c_rd_valid),   32'h2);
         step();
      end
      check("t5_bp_out_cnt", 32'(dut.out_cnt_q), 32'h3);
      c_rd_ready = 4'b0010;
      #1;
      check("t5_bp_release", 32'(m_axi_rready), 32'h1);
      step();
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      c_rd_ready   = '0;
      #1;
      check("t5_out_cnt2", 32'(dut.out_cnt_q), 32'h2);

      // Reset mid-burst with arvalid pending
      m_axi_arready = 1'b0;
      set_req(3, 32'h0000_0400, 8'd0);
      c_req_valid = 4'b1000;
      #1;
      check("t6_ready_ch3", 32'(c_req_ready), 32'h8);
      step();
      check("t6_arvalid_pre", 32'(m_axi_arvalid), 32'h1);
      for (int ch = 0; ch < N_CH; ch++) set_req(ch, 32'h0000_1000 * ch, 8'd0);
      c_req_valid = 4'b1111;
      aresetn = 1'b0;
      #1;
      check("t6_rst_arvalid", 32'(m_axi_arvalid), 32'h0);
      check("t6_rst_ready",   32'(c_req_ready),   32'h0);
      check("t6_rst_err",     32'(c_req_err),     32'h0);
      check("t6_rst_arid",    32'(m_axi_arid),    32'h0);
      check("t6_rst_araddr",  m_axi_araddr,       32'h0);
      check("t6_rst_out_cnt", 32'(dut.out_cnt_q), 32'h0);
      step();
      aresetn = 1'b1;
      m_axi_arready = 1'b1;
      #1;

      // All channels requesting, no R traffic: IDs 0..3 then full
      for (int k = 0; k < 4; k++) begin
         check("t2_grant", 32'(c_req_ready), 32'h1 << k);
         step();
         check("t2_arvalid", 32'(m_axi_arvalid), 32'h1);
         check("t2_arid",    32'(m_axi_arid),    32'(k));
         step();
      end
      check("t2_out_cnt4", 32'(dut.out_cnt_q), 32'h4);
      check("t2_full_a",   32'(c_req_ready),   32'h0);
      step();
      check("t2_full_b",   32'(c_req_ready),   32'h0);
      m_axi_rvalid = 1'b1;
      m_axi_rid    = 2'd0;
      m_axi_rlast  = 1'b1;
      c_rd_ready   = 4'b0001;
      #1;
      check("t2_full_hs_cycle", 32'(c_req_ready), 32'h0);
      step();
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      #1;
      check("t2_out_cnt3",   32'(dut.out_cnt_q), 32'h3);
      check("t2_grant_free", 32'(c_req_ready),   32'h1);
      c_req_valid = '0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ddr3_axi_rd_arbiter.md
# ddr3_axi_rd_arbiter

Parametrised N-channel read-port arbiter in front of the DDR3 SDRAM controller's AXI4 slave read channels (AR/R). Each client issues simple burst-read requests (address and beat count). The block round-robins them onto one AXI4 master read port, tags each burst with the client index as ARID, and routes R beats back by RID. It also adds behaviour the single-master port lacks:
- a global outstanding-burst limit;
- rejection of bursts that cross a 4 KB boundary.

## Interface
Parameters:
- N_CH, 4, number of client channels (2..16)
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (32/64/128/256)
- LEN_W, 8, client length field width; value = beats-1, max 255
- MAX_OUT, 4, max bursts in flight across all channels (1..15)
- ID_W (localparam), max(1, clog2(N_CH)), ARID/RID width

Ports:
- clk  in  1  single clock, shared with the controller's AXI clock
- aresetn  in  1  asynchronous active-low reset
- c_req_valid  in  N_CH  per-channel request valid
- c_req_ready  out  N_CH  per-channel request accept, one-cycle pulse
- c_req_addr  in  N_CH*ADDR_W  packed byte addresses, channel i at [i*ADDR_W +: ADDR_W]
- c_req_len  in  N_CH*LEN_W  packed beats-1
- c_req_err  out  N_CH  one-cycle pulse: request rejected (4 KB crossing)
- c_rd_valid  out  N_CH  read beat valid for channel RID
- c_rd_ready  in  N_CH  per-channel beat accept
- c_rd_data  out  DATA_W  shared read data (= m_axi_rdata)
- c_rd_last  out  1  last beat of burst (= m_axi_rlast)
- c_rd_err  out  1  beat error (= m_axi_rresp[1])
- m_axi_arid / araddr / arlen / arsize / arburst  out  ID_W / ADDR_W / 8 / 3 / 2  AR channel
- m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_rid / rdata / rresp / rlast / rvalid  in  ID_W / DATA_W / 2 / 1 / 1
- m_axi_rready  out  1

## Operation
- FSM states: IDLE, ISSUE.
- **IDLE:** the rr_arbiter picks the first requesting channel at or after rr_ptr, but only if out_cnt < MAX_OUT.
  - Granted channel g gets c_req_ready[g]=1 in the same cycle (combinational).
  - If the request crosses 4 KB, i.e. addr[11:0] + (len+1)*(DATA_W/8) > 4096:
    - c_req_err[g] pulses on the next cycle;
    - no AR is issued and the FSM stays in IDLE;
    - rr_ptr advances to g+1 mod N_CH.
  - Otherwise the AR registers load (arid=g, araddr, arlen=len, arsize=clog2(DATA_W/8), arburst=INCR 2'b01) and the FSM goes to ISSUE.
- **ISSUE:** m_axi_arvalid=1 and AR fields held stable until m_axi_arready. Then arvalid drops, out_cnt++, rr_ptr = g+1 mod N_CH, FSM returns to IDLE.
- **R routing** (combinational):
  - c_rd_valid[rid] = m_axi_rvalid; all other c_rd_valid bits are 0;
  - m_axi_rready = c_rd_ready[rid];
  - rid >= N_CH: rready=1, beat dropped.
- **out_cnt:**
  - decrements on the R handshake with rlast=1;
  - AR handshake and last-beat handshake in the same cycle leave it unchanged;
  - never exceeds MAX_OUT, never underflows.
- Per-channel ordering is guaranteed by the controller (same ID → in order). Interleaving across IDs is passed through.

## Timing
- **Reset values:**
  - c_req_ready=0, c_req_err=0, m_axi_arvalid=0;
  - AR fields 0, except arburst=2'b01 and arsize=clog2(DATA_W/8);
  - out_cnt=0, rr_ptr=0, FSM=IDLE.
- **Request latency:** c_req_valid seen in IDLE at cycle t → c_req_ready at t, arvalid at t+1.
- **Throughput:** max one AR per 2 cycles (ISSUE→IDLE→ISSUE).
- **Full:** with out_cnt==MAX_OUT, no grant is made and c_req_ready stays 0. A grant becomes possible the cycle after the freeing last-beat handshake.
- **Back-pressure:** an R beat stalls as long as the addressed client holds c_rd_ready low. Other channels' beats behind it also stall.
- **Reset mid-burst:** in-flight bursts are abandoned. The controller shares aresetn, so it is reset at the same time.

## Structure
- Package ddr_axi_pkg holds:
  - AXI_BURST_INCR;
  - response codes OKAY/SLVERR/DECERR;
  - AXI_4KB=4096;
  - a function axi_size(DATA_W) returning clog2(DATA_W/8).
- Sub-module rr_arbiter: N_CH-wide round-robin with one-hot grant. Inputs req, ptr, enable; output grant index.

## Test plan
- Single request ch2, addr 0xBC000100, len 7, arready held 1 → c_req_ready[2] pulses at t, arvalid at t+1 with arid=2, arlen=7, arburst=01; 8 beats return with rid=2 → c_rd_valid[2] only, c_rd_last on beat 8, out_cnt back to 0.
- All 4 channels requesting continuously, MAX_OUT=4, no R traffic → ARIDs issued in order 0,1,2,3; the 5th grant is blocked until one rlast handshake.
- ch1 request addr 0x00000FF0, len 7, DATA_W=32 (32 bytes, crosses 4 KB) → c_req_ready[1] and c_req_err[1] pulse, no AR issued, the next grant goes to ch2.
- arready held 0 for 10 cycles → arvalid stays 1 and araddr/arlen/arid stay stable throughout; a new c_req_valid on another channel is not granted until the handshake completes.
- AR handshake and rlast handshake in the same cycle at out_cnt=3 → out_cnt stays 3. R beat with rid=1 while c_rd_ready[1]=0 → rready=0 and the beat is held.
- aresetn asserted mid-burst (out_cnt=2, arvalid=1) → all outputs at reset values within the same cycle; after release, the first grant goes to ch0 under the round-robin rule.
